// File: rtl/cic_comp_deci2.sv
// CIC compensation FIR with decimation by 2: one registered multiplier, one accumulator.
// Optional macro CIC_COMP_SAT_EN selects output saturation instead of two's-complement wrap.
module cic_comp_deci2 #(
    parameter int W    = 10,
    parameter int CW   = 16,
    parameter int TAPS = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_en,
    input  logic signed [W-1:0]         in,
    input  logic                        coef_we,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic signed [CW-1:0]        coef_data,
    output logic signed [W-1:0]         out,
    output logic                        out_valid,
    output logic                        busy,
    output logic                        overrun
);
    localparam int AW    = $clog2(TAPS);
    localparam int DEPTH = 2 ** $clog2(TAPS + 2);
    localparam int PW    = $clog2(DEPTH);
    localparam int ACCW  = W + CW + AW;
    localparam int RW    = ACCW - (CW - 1);
    localparam logic [AW-1:0]        LAST = AW'(TAPS - 1);
    localparam logic signed [CW-1:0] UNITY = CW'(2 ** (CW - 1) - 1);
    localparam logic signed [RW-1:0] RMAX = RW'(2 ** (W - 1) - 1);
    localparam logic signed [RW-1:0] RMIN = ~RMAX;

    typedef enum logic [1:0] {IDLE, MAC, FLUSH, OUT} state_t;
    state_t state, state_nxt;

    logic signed [W-1:0]      sbuf [DEPTH];
    logic signed [CW-1:0]     coef [TAPS];
    logic [PW-1:0]            wp, base, rd_addr;
    logic                     phase, trig, trig_q;
    logic [AW-1:0]            tap;
    logic                     mac_en, out_load, prod_v;
    logic signed [W+CW-1:0]   prod;
    logic signed [ACCW-1:0]   acc, rsum;
    logic signed [RW-1:0]     rnd;
    logic signed [W-1:0]      res;

    assign trig = in_en & phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) sbuf[i] <= '0;
            wp    <= '0;
            phase <= 1'b0;
        end else if (in_en) begin
            sbuf[wp] <= in;
            wp       <= wp + PW'(1);
            phase    <= ~phase;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) coef[i] <= (i == TAPS / 2) ? UNITY : '0;
        end else if (coef_we && coef_addr <= LAST) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // A trigger seen while busy still stores its sample but never starts a pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_q  <= 1'b0;
            base    <= '0;
            overrun <= 1'b0;
        end else begin
            trig_q <= trig & ~busy;
            if (trig & ~busy) base <= wp;
            if (trig & busy) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (trig_q) state_nxt = MAC;
            MAC:     if (tap == LAST) state_nxt = FLUSH;
            FLUSH:   state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mac_en   = (state == MAC);
        out_load = (state == OUT);
        busy     = (state != IDLE) | out_valid;
    end

    assign rd_addr = base - PW'(tap);

    always_ff @(posedge clk) begin
        if (rst || !mac_en) tap <= '0;
        else                tap <= tap + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod   <= '0;
            prod_v <= 1'b0;
            acc    <= '0;
        end else begin
            prod   <= (W + CW)'(sbuf[rd_addr]) * (W + CW)'(coef[tap]);
            prod_v <= mac_en;
            if (trig_q)      acc <= '0;
            else if (prod_v) acc <= acc + ACCW'(prod);
        end
    end

    assign rsum = acc + ACCW'(2 ** (CW - 2));
    assign rnd  = rsum[ACCW-1:CW-1];

    always_comb begin
        res = rnd[W-1:0];
`ifdef CIC_COMP_SAT_EN
        if (rnd > RMAX)      res = RMAX[W-1:0];
        else if (rnd < RMIN) res = RMIN[W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_load;
            if (out_load) out <= res;
        end
    end
endmodule
